fpunpack_pipe: RTL and testbench
================================

Name: fpunpack_pipe

Overview:
- Registered operand-unpack stage directly upstream of the FPU classify and compare logic.
- Takes a raw FLEN-bit register-file operand and its format, and checks NaN-boxing.
- Decodes sign, exponent and fraction into double-width fields, and produces the per-operand flags the classify stage consumes: sign, NaN, signaling NaN, subnormal, zero and infinity.
- Valid/ready handshake, 2-entry elastic buffer, so back-pressure from the execute stage never drops an operand.

Parameters:
- FLEN, 64: operand width. Only 64 is supported.
- ZFH_SUPPORTED, 1: half-precision decode enable. When 0, Fmt=10 is treated as reserved.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- InValid  in  1  upstream operand valid
- InReady  out  1  stage can accept an operand
- X  in  FLEN  raw operand
- Fmt  in  2  format: 00=S, 01=D, 10=H, 11=reserved
- OutValid  out  1  decoded operand valid
- OutReady  in  1  downstream accepts
- Xs  out  1  sign
- Xe  out  11  exponent, rebiased to double bias
- Xm  out  52  fraction, left-justified
- XNaN  out  1  NaN
- XSNaN  out  1  signaling NaN
- XSubnorm  out  1  subnormal
- XZero  out  1  zero
- XInf  out  1  infinity
- XBoxErr  out  1  S/H operand was improperly NaN-boxed
- FmtErr  out  1  reserved format

Behaviour:
- Reset (reset_n low, asynchronous):
  - Buffer emptied and OutValid=0 immediately; InReady=0 while reset_n is low.
  - All data and flag outputs are 0.
  - After release, InReady=1 on the first clk edge.
- Handshake:
  - Transfer in on clk rising when InValid&InReady; transfer out when OutValid&OutReady.
  - Latency is 1 cycle: an operand accepted at edge N is presented at OutValid after edge N.
  - Outputs are held stable while OutValid&~OutReady.
- Buffer:
  - Two entries, head and skid, with Count in 0..2.
  - InReady = (Count<2).
  - Simultaneous accept and drain leaves Count unchanged; with Count=1 this is full throughput, 1 operand per cycle.
  - Count=2 with OutReady=0: InReady=0 and input is ignored.
  - Strict FIFO order.
  - Count never wraps. An input while full is not accepted; an output while empty is not possible.
- Decode is combinational before the buffer; entries store decoded fields.
- Boxing:
  - S requires X[63:32] all ones; H requires X[63:16] all ones.
  - On failure: XBoxErr=1 and the operand is treated as canonical quiet NaN: Xs=0, Xe=7FF, Xm=bit51 only, XNaN=1, all other flags 0.
- Field extraction:
  - D: Xs=X[63], E=X[62:52], F=X[51:0].
  - S: Xs=X[31], E=X[30:23], F=X[22:0], placed at Xm[51:29] with zeros below.
  - H: Xs=X[15], E=X[14:10], F=X[9:0], placed at Xm[51:42] with zeros below.
- Flags:
  - Emax means E is all ones; Ezero means E is all zeros.
  - XInf = Emax & F==0.
  - XNaN = Emax & F!=0.
  - XSNaN = XNaN & ~F msb.
  - XZero = Ezero & F==0.
  - XSubnorm = Ezero & F!=0.
  - All flags are mutually exclusive except XSNaN, which implies XNaN.
- Exponent:
  - Emax maps to Xe=7FF.
  - Ezero maps to Xe=0: subnormals are not normalised here.
  - Otherwise Xe = E - bias + 1023, where bias is 127 for S and 15 for H. Computed in 11-bit unsigned arithmetic; it cannot overflow for S or H.
- Reserved format (Fmt=11, or Fmt=10 when ZFH_SUPPORTED=0):
  - FmtErr=1 and the canonical quiet NaN is produced.
  - XBoxErr=0 in this case.
- Reset mid-operation discards all buffered entries; no partial entry survives.

Test Plan:
- Boxed S 1.0: X=FFFFFFFF_3F800000, Fmt=00, OutReady=1 → next cycle OutValid=1, Xs=0, Xe=3FF, Xm=0, all flags 0.
- Unboxed S: X=00000000_3F800000, Fmt=00 → XBoxErr=1, XNaN=1, XSNaN=0, Xe=7FF, Xm=8_0000_0000_0000.
- D signaling NaN X=7FF00000_00000001 → XNaN=1 and XSNaN=1. D -Inf X=FFF00000_00000000 → Xs=1, XInf=1.
- H subnormal: X=FFFFFFFF_FFFF0001, Fmt=10 → XSubnorm=1, Xe=0, Xm=bit42 set. Same stimulus with Fmt=11 → FmtErr=1, XNaN=1.
- Back-pressure:
  - Hold OutReady=0 and present operands A, B, C on consecutive cycles → A and B accepted, InReady=0 when C is presented, C held upstream.
  - Then raise OutReady → outputs appear in order A, B, C, one per cycle, with no duplicates.
- Async reset with Count=2: drop reset_n between clock edges → OutValid=0 and InReady=0 immediately.
  - After release, a new operand D is accepted → D is the first output; A and B never appear.

Source files
------------

// File: rtl/fpunpack_pipe_if.sv
// Handshake bundles for the FPU operand-unpack stage.
//
// fpunpack_in_if  : raw operand stream from the register-file read port.
//   InValid - operand valid (master -> slave)
//   InReady - slave can take an operand (slave -> master)
//   X       - raw FLEN-bit operand
//   Fmt     - 00=S, 01=D, 10=H, 11=reserved
//
// fpunpack_out_if : decoded operand stream towards classify/compare.
//   OutValid/OutReady - handshake
//   Xs, Xe, Xm        - sign, double-biased exponent, left-justified fraction
//   XNaN..XInf        - classification flags
//   XBoxErr, FmtErr   - NaN-boxing failure, reserved format
interface fpunpack_in_if #(
    parameter int FLEN = 64
);
    logic            InValid;
    logic            InReady;
    logic [FLEN-1:0] X;
    logic [1:0]      Fmt;

    modport master (output InValid, X, Fmt, input InReady);
    modport slave  (input InValid, X, Fmt, output InReady);
endinterface

interface fpunpack_out_if;
    logic        OutValid;
    logic        OutReady;
    logic        Xs;
    logic [10:0] Xe;
    logic [51:0] Xm;
    logic        XNaN;
    logic        XSNaN;
    logic        XSubnorm;
    logic        XZero;
    logic        XInf;
    logic        XBoxErr;
    logic        FmtErr;

    modport master (output OutValid, Xs, Xe, Xm, XNaN, XSNaN, XSubnorm, XZero,
                           XInf, XBoxErr, FmtErr,
                    input  OutReady);
    modport slave  (input  OutValid, Xs, Xe, Xm, XNaN, XSNaN, XSubnorm, XZero,
                           XInf, XBoxErr, FmtErr,
                    output OutReady);
endinterface

// File: rtl/fpunpack_pipe.sv
// Registered operand-unpack stage in front of FPU classify/compare.
// Decodes a raw S/D/H operand (with NaN-box check) into double-width
// sign/exponent/fraction plus class flags, and hands it downstream through a
// 2-entry elastic buffer (head + skid) so back-pressure never drops data.
//
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset; empties the buffer
//   in_bus  - fpunpack_in_if.slave  : InValid/InReady/X/Fmt
//   out_bus - fpunpack_out_if.master: OutValid/OutReady and decoded fields
module fpunpack_pipe #(
    parameter int FLEN          = 64,
    parameter bit ZFH_SUPPORTED = 1'b1
) (
    input logic            clk,
    input logic            reset_n,
    fpunpack_in_if.slave   in_bus,
    fpunpack_out_if.master out_bus
);

    typedef struct packed {
        logic        xs;
        logic [10:0] xe;
        logic [51:0] xm;
        logic        nan;
        logic        snan;
        logic        subnorm;
        logic        zero;
        logic        inf;
        logic        box_err;
        logic        fmt_err;
    } dec_t;

    localparam logic [51:0] QNAN_M = 52'h8_0000_0000_0000;

    function automatic dec_t canon_nan(input logic box_err, input logic fmt_err);
        dec_t d;
        d         = '0;
        d.xe      = 11'h7FF;
        d.xm      = QNAN_M;
        d.nan     = 1'b1;
        d.box_err = box_err;
        d.fmt_err = fmt_err;
        return d;
    endfunction

    function automatic dec_t decode(input logic [FLEN-1:0] x, input logic [1:0] fmt);
        dec_t        d;
        logic        sign;
        logic [10:0] e_norm;
        logic [51:0] f;
        logic        emax;
        logic        ezero;
        logic        boxed;
        logic        resv;
        d      = '0;
        sign   = 1'b0;
        e_norm = '0;
        f      = '0;
        emax   = 1'b0;
        ezero  = 1'b0;
        boxed  = 1'b1;
        resv   = (fmt == 2'b11) || ((fmt == 2'b10) && !ZFH_SUPPORTED);
        // Narrow exponents are rebiased by adding (1023 - bias); the sum
        // stays far below 7FF so 11 bits never overflow.
        case (fmt)
            2'b01: begin
                sign   = x[63];
                f      = x[51:0];
                emax   = &x[62:52];
                ezero  = ~|x[62:52];
                e_norm = x[62:52];
            end
            2'b00: begin
                sign   = x[31];
                f      = {x[22:0], 29'd0};
                emax   = &x[30:23];
                ezero  = ~|x[30:23];
                e_norm = {3'd0, x[30:23]} + 11'd896;
                boxed  = &x[63:32];
            end
            2'b10: begin
                sign   = x[15];
                f      = {x[9:0], 42'd0};
                emax   = &x[14:10];
                ezero  = ~|x[14:10];
                e_norm = {6'd0, x[14:10]} + 11'd1008;
                boxed  = &x[63:16];
            end
            default: ;
        endcase
        if (resv) begin
            d = canon_nan(1'b0, 1'b1);
        end else if (!boxed) begin
            d = canon_nan(1'b1, 1'b0);
        end else begin
            d.xs      = sign;
            d.xm      = f;
            d.inf     = emax & ~|f;
            d.nan     = emax & |f;
            // Fraction is left-justified, so bit 51 is the quiet bit for every format.
            d.snan    = emax & |f & ~f[51];
            d.zero    = ezero & ~|f;
            d.subnorm = ezero & |f;
            d.xe      = emax ? 11'h7FF : (ezero ? 11'd0 : e_norm);
        end
        return d;
    endfunction

    // ---- p0: combinational decode of the incoming operand ----
    dec_t dec_p0;
    assign dec_p0 = decode(in_bus.X, in_bus.Fmt);

    // ---- p1: elastic buffer (head presented downstream, skid behind it) ----
    dec_t       head_p1;
    dec_t       skid_p1;
    logic [1:0] cnt_p1;
    logic       accept_en;
    logic       vld_p1;
    logic       push;
    logic       pop;

    assign vld_p1         = (cnt_p1 != 2'd0);
    // accept_en keeps InReady low through reset and until the first edge after release.
    assign in_bus.InReady = accept_en & (cnt_p1 != 2'd2);
    assign push           = in_bus.InValid & in_bus.InReady;
    assign pop            = vld_p1 & out_bus.OutReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_p1    <= 2'd0;
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            cnt_p1    <= cnt_p1 + {1'b0, push} - {1'b0, pop};
        end
    end

    // Entries carry no reset: they are only observable while cnt_p1 says so.
    always_ff @(posedge clk) begin
        if (push && ((cnt_p1 == 2'd0) || pop)) begin
            head_p1 <= dec_p0;
        end else if (pop && (cnt_p1 == 2'd2)) begin
            head_p1 <= skid_p1;
        end
        if (push && (cnt_p1 == 2'd1) && !pop) begin
            skid_p1 <= dec_p0;
        end
    end

    // ---- output: fields forced to zero whenever nothing is presented ----
    dec_t out_p1;
    assign out_p1 = vld_p1 ? head_p1 : '0;

    assign out_bus.OutValid = vld_p1;
    assign out_bus.Xs       = out_p1.xs;
    assign out_bus.Xe       = out_p1.xe;
    assign out_bus.Xm       = out_p1.xm;
    assign out_bus.XNaN     = out_p1.nan;
    assign out_bus.XSNaN    = out_p1.snan;
    assign out_bus.XSubnorm = out_p1.subnorm;
    assign out_bus.XZero    = out_p1.zero;
    assign out_bus.XInf     = out_p1.inf;
    assign out_bus.XBoxErr  = out_p1.box_err;
    assign out_bus.FmtErr   = out_p1.fmt_err;

endmodule

// File: tb/tb_fpunpack_pipe.sv
// Bench for fpunpack_pipe: directed vector table, back-pressure and async
// reset sequences, then random traffic against a queue-based reference.
module tb_fpunpack_pipe;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fpunpack_in_if #(.FLEN(64)) ib();
    fpunpack_out_if             ob();

    fpunpack_pipe #(.FLEN(64), .ZFH_SUPPORTED(1'b1)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .in_bus (ib),
        .out_bus(ob)
    );

    // {xs, xe, xm, nan, snan, subnorm, zero, inf, boxerr, fmterr}
    typedef logic [70:0] rec_t;

    typedef struct {
        string       name;
        logic [63:0] x;
        logic [1:0]  fmt;
        rec_t        exp;
    } vec_t;

    localparam logic [6:0] F_NAN  = 7'b1000000;
    localparam logic [6:0] F_SNAN = 7'b0100000;
    localparam logic [6:0] F_SUB  = 7'b0010000;
    localparam logic [6:0] F_ZERO = 7'b0001000;
    localparam logic [6:0] F_INF  = 7'b0000100;
    localparam logic [6:0] F_BOX  = 7'b0000010;
    localparam logic [6:0] F_FMT  = 7'b0000001;
    localparam logic [51:0] QM    = 52'h8_0000_0000_0000;

    vec_t vecs[$];
    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic rec_t actual();
        return {ob.Xs, ob.Xe, ob.Xm, ob.XNaN, ob.XSNaN, ob.XSubnorm, ob.XZero,
                ob.XInf, ob.XBoxErr, ob.FmtErr};
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input rec_t act, input rec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [63:0] x, input logic [1:0] fmt,
                       input logic xs, input logic [10:0] xe, input logic [51:0] xm,
                       input logic [6:0] fl);
        vec_t v;
        v.name = name;
        v.x    = x;
        v.fmt  = fmt;
        v.exp  = {xs, xe, xm, fl};
        vecs.push_back(v);
    endtask

    // Reference decode from the IEEE field layout: widths, bias and boxing
    // derived per format, arithmetic on plain integers.
    function automatic rec_t model(input logic [63:0] x, input logic [1:0] fmt);
        int          ew, fw, bias, top;
        logic [63:0] emask, fmask, e, f;
        logic        xs, nan, snan, sub, zero, inf;
        logic [10:0] xe;
        logic [51:0] xm;
        if (fmt == 2'b11) return {1'b0, 11'h7FF, QM, F_NAN | F_FMT};
        case (fmt)
            2'b00:   begin ew = 8;  fw = 23; bias = 127;  end
            2'b01:   begin ew = 11; fw = 52; bias = 1023; end
            default: begin ew = 5;  fw = 10; bias = 15;   end
        endcase
        top = ew + fw + 1;
        if (top < 64) begin
            if ((x >> top) != (~64'd0 >> top)) return {1'b0, 11'h7FF, QM, F_NAN | F_BOX};
        end
        emask = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << fw) - 64'd1;
        e     = (x >> fw) & emask;
        f     = x & fmask;
        xs    = x[top-1];
        xm    = 52'(f << (52 - fw));
        nan = 0; snan = 0; sub = 0; zero = 0; inf = 0;
        if (e == emask) begin
            xe = 11'h7FF;
            if (f == 0) inf = 1;
            else begin
                nan  = 1;
                snan = ~f[fw-1];
            end
        end else if (e == 0) begin
            xe = 11'd0;
            if (f == 0) zero = 1;
            else sub = 1;
        end else begin
            xe = 11'(e + 64'(1023 - bias));
        end
        return {xs, xe, xm, nan, snan, sub, zero, inf, 1'b0, 1'b0};
    endfunction

    task automatic gen_operand(output logic [63:0] x, output logic [1:0] fmt);
        int          ew, fw, top, cls;
        logic [63:0] e, f, s;
        fmt = 2'($urandom_range(0, 3));
        ew  = (fmt == 2'b00) ? 8 : (fmt == 2'b01) ? 11 : 5;
        fw  = (fmt == 2'b00) ? 23 : (fmt == 2'b01) ? 52 : 10;
        top = ew + fw + 1;
        cls = $urandom_range(0, 3);
        if (cls == 0) e = 0;
        else if (cls == 1) e = (64'd1 << ew) - 64'd1;
        else e = {32'd0, $urandom} % ((64'd1 << ew) - 64'd1);
        f = {$urandom, $urandom} & ((64'd1 << fw) - 64'd1);
        if ($urandom_range(0, 3) == 0) f = 0;
        s = {63'd0, 1'($urandom_range(0, 1))};
        x = {$urandom, $urandom};
        if (top < 64) begin
            if ($urandom_range(0, 7) != 0) x = ~64'd0;
            x = (x >> top) << top;
        end else begin
            x = 64'd0;
        end
        x = x | (s << (top - 1)) | (e << fw) | f;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a, b, c, d;
        reset_n     = 1'b0;
        ib.InValid  = 1'b0;
        ib.X        = '0;
        ib.Fmt      = 2'b00;
        ob.OutReady = 1'b0;

        add("s_one",        64'hFFFFFFFF_3F800000, 2'b00, 0, 11'h3FF, 52'h0, 7'b0);
        add("s_unboxed",    64'h00000000_3F800000, 2'b00, 0, 11'h7FF, QM, F_NAN | F_BOX);
        add("d_snan",       64'h7FF00000_00000001, 2'b01, 0, 11'h7FF, 52'h1, F_NAN | F_SNAN);
        add("d_neg_inf",    64'hFFF00000_00000000, 2'b01, 1, 11'h7FF, 52'h0, F_INF);
        add("h_subnorm",    64'hFFFFFFFF_FFFF0001, 2'b10, 0, 11'h000, 52'h400_0000_0000, F_SUB);
        add("resv_fmt",     64'hFFFFFFFF_FFFF0001, 2'b11, 0, 11'h7FF, QM, F_NAN | F_FMT);
        add("d_zero",       64'h00000000_00000000, 2'b01, 0, 11'h000, 52'h0, F_ZERO);
        add("s_qnan",       64'hFFFFFFFF_7FC00000, 2'b00, 0, 11'h7FF, QM, F_NAN);
        add("s_snan",       64'hFFFFFFFF_7F800001, 2'b00, 0, 11'h7FF, 52'h0000020000000, F_NAN | F_SNAN);
        add("h_one",        64'hFFFFFFFF_FFFF3C00, 2'b10, 0, 11'h3FF, 52'h0, 7'b0);
        add("h_unboxed",    64'hFFFFFFFF_00003C00, 2'b10, 0, 11'h7FF, QM, F_NAN | F_BOX);
        add("s_max_norm",   64'hFFFFFFFF_7F7FFFFF, 2'b00, 0, 11'h47E, 52'hFFFFFE0000000, 7'b0);
        add("s_neg_sub",    64'hFFFFFFFF_80000001, 2'b00, 1, 11'h000, 52'h0000020000000, F_SUB);
        add("h_neg_inf",    64'hFFFFFFFF_FFFFFC00, 2'b10, 1, 11'h7FF, 52'h0, F_INF);

        // Reset state
        repeat (2) @(negedge clk);
        chk_bit("rst_outvalid", ob.OutValid, 1'b0);
        chk_bit("rst_inready", ib.InReady, 1'b0);
        chk_rec("rst_data", actual(), '0);
        reset_n = 1'b1;
        @(negedge clk);
        chk_bit("rel_inready", ib.InReady, 1'b1);
        chk_bit("rel_outvalid", ob.OutValid, 1'b0);

        // Directed table, one operand per cycle
        ob.OutReady = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            ib.InValid = 1'b1;
            ib.X       = vecs[i].x;
            ib.Fmt     = vecs[i].fmt;
            chk_bit({vecs[i].name, "_inready"}, ib.InReady, 1'b1);
            @(negedge clk);
            ib.InValid = 1'b0;
            chk_bit({vecs[i].name, "_vld"}, ob.OutValid, 1'b1);
            chk_rec(vecs[i].name, actual(), vecs[i].exp);
        end
        @(negedge clk);
        chk_bit("tbl_drained", ob.OutValid, 1'b0);

        // Back-pressure: A, B fill the buffer, C waits upstream
        a = 64'hFFFFFFFF_40000000;
        b = 64'hFFFFFFFF_C0400000;
        c = 64'hFFFFFFFF_00000000;
        ob.OutReady = 1'b0;
        ib.InValid  = 1'b1;
        ib.Fmt      = 2'b00;
        ib.X        = a;
        @(negedge clk);
        ib.X = b;
        @(negedge clk);
        ib.X = c;
        chk_bit("bp_full_inready", ib.InReady, 1'b0);
        chk_rec("bp_head_a", actual(), model(a, 2'b00));
        @(negedge clk);
        chk_bit("bp_hold_inready", ib.InReady, 1'b0);
        chk_rec("bp_hold_a", actual(), model(a, 2'b00));
        ob.OutReady = 1'b1;
        @(negedge clk);
        chk_bit("bp_b_vld", ob.OutValid, 1'b1);
        chk_rec("bp_out_b", actual(), model(b, 2'b00));
        @(negedge clk);
        ib.InValid = 1'b0;
        chk_bit("bp_c_vld", ob.OutValid, 1'b1);
        chk_rec("bp_out_c", actual(), model(c, 2'b00));
        @(negedge clk);
        chk_bit("bp_drained", ob.OutValid, 1'b0);

        // Asynchronous reset while full
        ob.OutReady = 1'b0;
        ib.InValid  = 1'b1;
        ib.X        = a;
        @(negedge clk);
        ib.X = b;
        @(negedge clk);
        ib.InValid = 1'b0;
        chk_bit("ar_full_inready", ib.InReady, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk_bit("ar_outvalid", ob.OutValid, 1'b0);
        chk_bit("ar_inready", ib.InReady, 1'b0);
        chk_rec("ar_data", actual(), '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        d = 64'h40090000_00000000;
        ob.OutReady = 1'b1;
        ib.InValid  = 1'b1;
        ib.X        = d;
        ib.Fmt      = 2'b01;
        chk_bit("ar_rel_inready", ib.InReady, 1'b1);
        @(negedge clk);
        ib.InValid = 1'b0;
        chk_bit("ar_d_vld", ob.OutValid, 1'b1);
        chk_rec("ar_out_d", actual(), model(d, 2'b01));
        @(negedge clk);
        chk_bit("ar_no_stale", ob.OutValid, 1'b0);

        // Random traffic against the queue reference
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic [63:0] x;
            logic [1:0]  f;
            logic        iv, orr, pushed, popped;
            gen_operand(x, f);
            iv          = ($urandom_range(0, 3) != 0);
            orr         = ($urandom_range(0, 2) != 0);
            ib.InValid  = iv;
            ib.X        = x;
            ib.Fmt      = f;
            ob.OutReady = orr;
            chk_bit("rnd_inready", ib.InReady, sb.size() < 2);
            chk_bit("rnd_outvalid", ob.OutValid, sb.size() != 0);
            if (sb.size() != 0) chk_rec("rnd_data", actual(), sb[0]);
            pushed = iv && (sb.size() < 2);
            popped = orr && (sb.size() != 0);
            @(posedge clk);
            if (popped) void'(sb.pop_front());
            if (pushed) sb.push_back(model(x, f));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
